// File: rtl/esm_ooo_window.sv
// rtl/esm_ooo_window.sv - out-of-order issue window with register hazard tracking and latency scoreboard
// Optional ESM_INORDER_EN: restrict issue to entry 0 (issue order equals accept order).
module esm_ooo_window #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16,
  parameter int LAT                   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Instruction_word_size-1:0] Instr_in,
  input  logic                             in_valid,
  input  logic                             RegWrite,
  input  logic                             ALUSrc,
  output logic                             in_ready,
  input  logic                             flush,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             out_valid,
  output logic [$clog2(bs):0]              occupancy
);

  localparam int AW = $clog2(bs);
  localparam int CW = AW + 1;

  // Register numbers of 0 mean "no operand", so x0 never matches a hazard.
  typedef struct packed {
    logic [Instruction_word_size-1:0] instr;
    logic [4:0]                       dst;
    logic [4:0]                       s1;
    logic [4:0]                       s2;
  } ent_t;

  ent_t          win [bs];
  logic [CW-1:0] count;
  logic [3:0]    sb  [32];
  logic [bs-1:0] rdy;
  logic          issue;
  logic [AW-1:0] iss_idx;
  logic          acc;
  logic [AW-1:0] wr_ptr;
  ent_t          new_e;

  assign in_ready  = (count < CW'(bs));
  assign occupancy = count;
  assign acc       = in_valid && in_ready && (Instr_in != '0) && !flush;
  assign wr_ptr    = AW'(count - CW'(issue));

  always_comb begin
    new_e.instr = Instr_in;
    new_e.dst   = RegWrite ? Instr_in[11:7] : 5'd0;
    new_e.s1    = Instr_in[19:15];
    new_e.s2    = ALUSrc ? 5'd0 : Instr_in[24:20];
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < bs; i++) begin
      rdy[i] = (CW'(i) < count);
      for (int j = 0; j < i; j++) begin
        if (win[j].dst != 5'd0 && (win[j].dst == win[i].s1 || win[j].dst == win[i].s2 ||
                                   win[j].dst == win[i].dst))
          rdy[i] = 1'b0;
        if (win[i].dst != 5'd0 && (win[j].s1 == win[i].dst || win[j].s2 == win[i].dst))
          rdy[i] = 1'b0;
      end
      if (sb[win[i].s1] != 4'd0 || sb[win[i].s2] != 4'd0 || sb[win[i].dst] != 4'd0)
        rdy[i] = 1'b0;
    end
  end

  always_comb begin
    issue   = 1'b0;
    iss_idx = '0;
`ifdef ESM_INORDER_EN
    issue = rdy[0];
`else
    for (int i = bs - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        issue   = 1'b1;
        iss_idx = AW'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      out_valid <= 1'b0;
      Instr_out <= '0;
      for (int r = 0; r < 32; r++) sb[r] <= 4'd0;
    end else if (flush) begin
      count     <= '0;
      out_valid <= 1'b0;
      Instr_out <= '0;
      for (int r = 0; r < 32; r++) sb[r] <= 4'd0;
    end else begin
      out_valid <= issue;
      Instr_out <= issue ? win[iss_idx].instr : '0;
      for (int r = 1; r < 32; r++) sb[r] <= (sb[r] != 4'd0) ? sb[r] - 4'd1 : 4'd0;
      // A fresh load overrides the decrement for the same register.
      if (issue && win[iss_idx].dst != 5'd0) sb[win[iss_idx].dst] <= 4'(LAT - 1);
      count <= count + CW'(acc) - CW'(issue);
    end
  end

  // Entry storage needs no reset: validity is defined by count alone.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < bs - 1; i++)
        if (issue && AW'(i) >= iss_idx) win[i] <= win[i+1];
      if (acc) win[wr_ptr] <= new_e;
    end
  end

endmodule
